// File: rtl/load_store_unit.sv
// Load/store sequencer: checks RV32I load/store requests, issues one word-addressed
// byte-enabled memory access with an ack handshake, and returns one response pulse.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    func3_q, func3_d;
  logic [1:0]    off_q, off_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic          illegal, misaligned;
  logic [3:0]    req_be;
  logic [31:0]   req_lane_wdata;
  logic [31:0]   shifted;
  logic [31:0]   load_data;

  // Request decode: legality, alignment, lane enables and replicated store data.
  always_comb begin
    illegal    = (req_func3 == 3'b011) || (req_func3[2:1] == 2'b11) ||
                 (req_write && req_func3[2]);
    misaligned = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    case (req_func3[1:0])
      2'b00: begin
        req_be         = 4'b0001 << req_addr[1:0];
        req_lane_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be         = 4'b0011 << req_addr[1:0];
        req_lane_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be         = 4'b1111;
        req_lane_wdata = req_wdata;
      end
    endcase
  end

  // Load result extraction uses the offset and width latched at accept time.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (func3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    func3_d     = func3_q;
    off_d       = off_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          func3_d = req_func3;
          off_d   = req_addr[1:0];
          if (illegal || misaligned) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0;
          end else begin
            state_d     = ACCESS;
            cnt_d       = '0;
            mem_en_d    = 1'b1;
            mem_we_d    = req_write;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = req_be;
            mem_wdata_d = req_lane_wdata;
          end
        end
      end
      ACCESS: begin
        // An ack in the last allowed cycle takes priority over the timeout.
        if (mem_ack) begin
          state_d     = RESP;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = mem_we_q ? 32'h0 : load_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          mem_en_d    = 1'b0;
          mem_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      func3_q     <= 3'b000;
      off_q       <= 2'b00;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      func3_q     <= func3_d;
      off_q       <= off_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit: expected responses are queued at
// request time and checked when the response pulse appears.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pops the oldest expected response and compares it against the pulse now visible.
  task automatic popResponse(input string name);
    exp_t e;
    checkOutput({name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (sb.size() == 0) begin
      checkOutput({name, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput({name, "_rsp_err"}, 32'(rsp_err), 32'(e.err));
      checkOutput({name, "_rsp_rdata"}, rsp_rdata, e.rdata);
    end
  endtask

  // One full request: accept, optional memory access with ack in cycle ack_cyc
  // (0 = never), response pulse, then return to idle with held response data.
  task automatic applyStimulus(input string name, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input bit access, input logic [3:0] exp_be,
                               input logic [31:0] exp_wdata, input int ack_cyc,
                               input logic [31:0] rdata, input logic exp_err,
                               input logic [31:0] exp_rdata);
    exp_t e;
    bit   done;
    int   k;
    e.err   = exp_err;
    e.rdata = exp_rdata;
    sb.push_back(e);
    checkOutput({name, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_func3 = f3;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    if (!access) begin
      checkOutput({name, "_no_mem_en"}, 32'(mem_en), 32'd0);
    end else begin
      done = 1'b0;
      k    = 1;
      while (!done) begin
        checkOutput({name, "_mem_en"}, 32'(mem_en), 32'd1);
        if (k == 1) begin
          checkOutput({name, "_req_ready_busy"}, 32'(req_ready), 32'd0);
          checkOutput({name, "_rsp_idle"}, 32'(rsp_valid), 32'd0);
          checkOutput({name, "_mem_we"}, 32'(mem_we), 32'(wr));
          checkOutput({name, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
          checkOutput({name, "_mem_be"}, 32'(mem_be), 32'(exp_be));
          if (wr) checkOutput({name, "_mem_wdata"}, mem_wdata, exp_wdata);
        end
        if (k == ack_cyc) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        if (k == ack_cyc || k >= TIMEOUT) done = 1'b1;
        k++;
      end
      checkOutput({name, "_mem_en_drop"}, 32'(mem_en), 32'd0);
    end
    popResponse(name);
    tick();
    checkOutput({name, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    checkOutput({name, "_back_idle"}, 32'(req_ready), 32'd1);
    checkOutput({name, "_rdata_held"}, rsp_rdata, exp_rdata);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_func3 = 3'b000;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;
    tick();
    tick();
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] stores and loads");
    applyStimulus("sw", 1'b1, 3'b010, 32'h0000_0008, 32'hAABB_CCDD, 1'b1, 4'b1111,
                  32'hAABB_CCDD, 1, 32'h0, 1'b0, 32'h0);
    applyStimulus("lb", 1'b0, 3'b000, 32'h0000_0015, 32'h0, 1'b1, 4'b0010,
                  32'h0, 1, 32'h1234_80FF, 1'b0, 32'hFFFF_FF80);
    applyStimulus("lbu", 1'b0, 3'b100, 32'h0000_0015, 32'h0, 1'b1, 4'b0010,
                  32'h0, 1, 32'h1234_80FF, 1'b0, 32'h0000_0080);
    applyStimulus("sh", 1'b1, 3'b001, 32'h0000_001A, 32'h0000_BEEF, 1'b1, 4'b1100,
                  32'hBEEF_BEEF, 1, 32'h0, 1'b0, 32'h0);
    applyStimulus("lh", 1'b0, 3'b001, 32'h0000_001A, 32'h0, 1'b1, 4'b1100,
                  32'h0, 1, 32'h8001_0000, 1'b0, 32'hFFFF_8001);
    applyStimulus("lhu", 1'b0, 3'b101, 32'h0000_001A, 32'h0, 1'b1, 4'b1100,
                  32'h0, 2, 32'h8001_0000, 1'b0, 32'h0000_8001);
    applyStimulus("sb3", 1'b1, 3'b000, 32'h0000_0007, 32'h1234_5678, 1'b1, 4'b1000,
                  32'h7878_7878, 3, 32'h0, 1'b0, 32'h0);
    applyStimulus("lb3", 1'b0, 3'b000, 32'h0000_0023, 32'h0, 1'b1, 4'b1000,
                  32'h0, 1, 32'h7F00_0000, 1'b0, 32'h0000_007F);

    $display("[TB] error paths");
    applyStimulus("lw_mis", 1'b0, 3'b010, 32'h0000_0006, 32'h0, 1'b0, 4'b0,
                  32'h0, 0, 32'h0, 1'b1, 32'h0);
    applyStimulus("sbu_ill", 1'b1, 3'b100, 32'h0000_0010, 32'h55, 1'b0, 4'b0,
                  32'h0, 0, 32'h0, 1'b1, 32'h0);
    applyStimulus("ld_ill", 1'b0, 3'b011, 32'h0000_0010, 32'h0, 1'b0, 4'b0,
                  32'h0, 0, 32'h0, 1'b1, 32'h0);
    applyStimulus("lh_mis", 1'b0, 3'b001, 32'h0000_0001, 32'h0, 1'b0, 4'b0,
                  32'h0, 0, 32'h0, 1'b1, 32'h0);

    $display("[TB] timeout");
    applyStimulus("lw_to", 1'b0, 3'b010, 32'h0000_0040, 32'h0, 1'b1, 4'b1111,
                  32'h0, 0, 32'h0, 1'b1, 32'h0);
    applyStimulus("lw_ack16", 1'b0, 3'b010, 32'h0000_0040, 32'h0, 1'b1, 4'b1111,
                  32'h0, TIMEOUT, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF);

    $display("[TB] stray ack while idle");
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checkOutput("stray_ack_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("stray_ack_mem_en", 32'(mem_en), 32'd0);
    checkOutput("stray_ack_ready", 32'(req_ready), 32'd1);

    $display("[TB] reset mid-transaction");
    req_valid = 1'b1;
    req_write = 1'b0;
    req_func3 = 3'b010;
    req_addr  = 32'h0000_0080;
    tick();
    req_valid = 1'b0;
    checkOutput("midrst_mem_en_before", 32'(mem_en), 32'd1);
    reset   = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h1111_2222;
    tick();
    reset   = 1'b0;
    mem_ack = 1'b0;
    checkOutput("midrst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("midrst_ready", 32'(req_ready), 32'd1);
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("midrst_mem_addr", mem_addr, 32'h0);
    tick();
    checkOutput("midrst_no_late_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
